// File: rtl/spi_regbank_pkg.sv
// Shared definitions for the SPI/local register bank: grant states and the
// standard register map used by the Raspberry Pi link.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPI_RD = 2'd1,
    SPI_WR = 2'd2,
    LOCAL  = 2'd3
  } grant_state_e;

  localparam int REG_TO_PI       = 0;
  localparam int REG_SPEED_FR_RR = 1;
  localparam int REG_SPEED_FL_RL = 2;
  localparam int REG_X_POS       = 3;
  localparam int REG_Y_POS       = 4;
  localparam int REG_THETA       = 5;
  localparam int REG_ACTIONS     = 6;
  localparam int REG_ADV_X       = 7;
  localparam int REG_ADV_Y       = 8;

endpackage

// File: rtl/spi_regbank_arbiter_rr_arbiter.sv
// N_REQ-wide round-robin arbiter: search starts at the pointer, which moves
// to one past the granted index whenever a grant is issued.
module rr_arbiter
  import spi_regbank_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int idx;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_o) ptr_d = (int'(idx_o) == N_REQ - 1) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spi_regbank_arbiter.sv
// Single-port 2**ADDR_W x DATA_W register bank shared by the SPI link and
// N_REQ local requesters; one access per cycle, SPI read > SPI write > local.
module spi_regbank_arbiter
  import spi_regbank_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    spi_rd_req,
  input  logic [ADDR_W-1:0]       spi_rd_addr,
  output logic                    spi_rd_valid,
  output logic [DATA_W-1:0]       spi_rd_data,
  input  logic                    spi_wr_req,
  input  logic [ADDR_W-1:0]       spi_wr_addr,
  input  logic [DATA_W-1:0]       spi_wr_data,
  output logic                    spi_ovf,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = $clog2(N_REQ);

  logic [DATA_W-1:0] bank_q [DEPTH];
  logic              rd_pend_q, wr_pend_q, ovf_q, gnt_we_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q, spi_rd_data_q, rsp_rdata_q;
  logic [N_REQ-1:0]  gnt_q;
  grant_state_e      state_q, state_d;

  logic [ADDR_W-1:0] loc_addr  [N_REQ];
  logic [DATA_W-1:0] loc_wdata [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign loc_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign loc_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // A fresh SPI pulse supersedes a still-pending request of the same type, and
  // any SPI pulse reserves the next cycle so SPI is always ordered ahead of
  // locals arriving alongside it.
  logic rd_go, wr_go, local_ok;
  assign rd_go    = rd_pend_q & ~spi_rd_req;
  assign wr_go    = wr_pend_q & ~spi_wr_req & ~rd_go;
  assign local_ok = ~rd_pend_q & ~wr_pend_q & ~spi_rd_req & ~spi_wr_req;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .clk   (clk),
    .rst_n (reset_n),
    .req_i (local_ok ? req_valid : '0),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d = IDLE;
    if (rd_go)        state_d = SPI_RD;
    else if (wr_go)   state_d = SPI_WR;
    else if (arb_any) state_d = LOCAL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      state_q       <= IDLE;
      rd_pend_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      ovf_q         <= 1'b0;
      gnt_q         <= '0;
      gnt_we_q      <= 1'b0;
      spi_rd_data_q <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= arb_gnt;
      gnt_we_q <= req_we[arb_idx];
      if ((spi_rd_req && rd_pend_q) || (spi_wr_req && wr_pend_q)) ovf_q <= 1'b1;

      if (spi_rd_req) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= spi_rd_addr;
      end else if (rd_go) begin
        rd_pend_q <= 1'b0;
      end

      if (spi_wr_req) begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= spi_wr_addr;
        wr_data_q <= spi_wr_data;
      end else if (wr_go) begin
        wr_pend_q <= 1'b0;
      end

      case (state_d)
        SPI_RD: spi_rd_data_q <= bank_q[rd_addr_q];
        SPI_WR: bank_q[wr_addr_q] <= wr_data_q;
        LOCAL: begin
          if (req_we[arb_idx]) bank_q[loc_addr[arb_idx]] <= loc_wdata[arb_idx];
          else                 rsp_rdata_q <= bank_q[loc_addr[arb_idx]];
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = arb_gnt;
  assign spi_rd_valid = (state_q == SPI_RD);
  assign spi_rd_data  = spi_rd_data_q;
  assign spi_ovf      = ovf_q;
  assign rsp_valid    = (state_q == LOCAL && !gnt_we_q) ? gnt_q : '0;
  assign rsp_rdata    = rsp_rdata_q;

endmodule

// File: doc/spi_regbank_arbiter.md
Name: spi_regbank_arbiter

Overview:
- Owns the shared 16x32 register bank that carries data between the Raspberry Pi SPI link and FPGA logic (odometry, motor speed, action flags).
- Arbitrates single-port access per cycle between the SPI transaction side (one read, one write channel) and N_REQ local requesters.
- Sits between the SPI slave shift/FSM logic and the motion/odometry blocks; replaces ad-hoc per-slot register copies with one arbitrated bank.

Parameters:
N_REQ, 4, number of local requesters (2..8)
ADDR_W, 4, register address width (bank depth 2**ADDR_W)
DATA_W, 32, register data width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
spi_rd_req  in  1  one-cycle pulse: SPI needs register spi_rd_addr
spi_rd_addr  in  ADDR_W  SPI read address, sampled with spi_rd_req
spi_rd_valid  out  1  one-cycle pulse: spi_rd_data holds requested word
spi_rd_data  out  DATA_W  SPI read data, held until next spi_rd_valid
spi_wr_req  in  1  one-cycle pulse: commit spi_wr_data to spi_wr_addr
spi_wr_addr  in  ADDR_W  SPI write address
spi_wr_data  in  DATA_W  SPI write data
spi_ovf  out  1  sticky: SPI request arrived while same-type request still pending
req_valid  in  N_REQ  local request valid, held until accepted
req_we  in  N_REQ  1=write, 0=read, per requester
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
req_ready  out  N_REQ  one-hot accept, combinational from arbiter state
rsp_valid  out  N_REQ  one-hot read response pulse, one cycle after accept
rsp_rdata  out  DATA_W  shared read data, valid with any rsp_valid bit

Behaviour:
- Reset (async assert, sync deassert by clk): bank all zero; spi_rd_valid=0, spi_rd_data=0, spi_ovf=0, req_ready=0, rsp_valid=0, rsp_rdata=0; RR pointer=0; pending flags cleared.
- Mid-operation reset: discard all pending/in-flight requests; no rsp_valid or spi_rd_valid after deassert until a new request.
- SPI requests latched into pending flags rd_pend/wr_pend (with address/data) on the pulse cycle.
- If a pulse arrives while its own pending flag is set: the new request replaces the latched one; spi_ovf set; clears only on reset.
- One bank access per cycle; priority: rd_pend > wr_pend > local round-robin.
- Grant FSM states: IDLE, SPI_RD, SPI_WR, LOCAL.
  - Each cycle, choose the next state from pending/valid inputs; IDLE when nothing pending.
  - No state persists more than one cycle without re-evaluation.
- SPI read:
  - Served the cycle after the pulse when nothing is ahead of it.
  - spi_rd_valid pulses 2 cycles after spi_rd_req (pulse-to-grant 1 cycle, registered read 1 cycle).
  - Worst case 3 cycles if a pulse lands while wr_pend is mid-grant.
- SPI write: the bank updates at the end of the grant cycle; a read granted the following cycle returns the new value.
- Local arbitration:
  - Round-robin starts at the pointer; the pointer moves to (granted index + 1) mod N_REQ.
  - req_ready[i] high exactly in the grant cycle; requester drops or changes req_valid[i] the following cycle.
  - Local read: rsp_valid[i] and rsp_rdata the cycle after req_ready[i].
- Same-address collisions:
  - SPI write and local write in the same cycle: SPI is granted first and local next, so the local value is the final value.
  - Local read in the cycle after a write returns the written value; no bypass is needed since writes commit before the next access.
- Out-of-range address: impossible for ADDR_W-wide addresses; whole 2**ADDR_W bank implemented.
- Starvation bound: a local request waits at most N_REQ-1 local grants plus 2 SPI grants.

Decomposition:
- Package spi_regbank_pkg:
  - grant-state enum (IDLE, SPI_RD, SPI_WR, LOCAL)
  - localparams for standard register map: 0 TO_PI, 1 SPEED_FR_RR, 2 SPEED_FL_RL, 3 X_POS, 4 Y_POS, 5 THETA, 6 ACTIONS, 7 ADV_X, 8 ADV_Y
- Sub-module rr_arbiter (N_REQ-wide round-robin with pointer update) is natural; bank and FSM stay in the top.

Test Plan:
- Reset, then spi_rd_req addr 3 → spi_rd_valid exactly 2 cycles later, data 0x00000000; assert reset_n mid-read → no spi_rd_valid.
- spi_wr_req addr 5 data 0xDEADBEEF, next cycle spi_rd_req addr 5 → spi_rd_data 0xDEADBEEF, spi_ovf stays 0.
- All 4 local reads valid continuously, no SPI → ready grants 0,1,2,3,0 on consecutive cycles; each rsp_valid one cycle after its ready.
- Same cycle: spi_wr_req addr 2 data 0x11111111 and local 1 write addr 2 data 0x22222222 → SPI granted first, local next; subsequent read of addr 2 = 0x22222222.
- Two spi_rd_req pulses on back-to-back cycles while local writes hog arbitration → spi_ovf=1, served address is the second pulse's, one spi_rd_valid only.
- Local 0 read with rd_pend and wr_pend set → local 0 ready no later than cycle 3 after request; rsp_rdata matches bank content.
